// File: rtl/instr_pkg.sv
// Shared types for the instruction encoder: field widths, opcodes, FSM states
// and the queued-entry layout.
package instr_pkg;

    localparam int DEF_OP_SIZE      = 4;
    localparam int DEF_PARAM_A_SIZE = 4;
    localparam int DEF_PARAM_B_SIZE = 4;
    localparam int DEF_REPEAT_W     = 4;
    localparam int CODE_W = DEF_OP_SIZE + DEF_PARAM_A_SIZE + DEF_PARAM_B_SIZE;

    typedef enum logic [DEF_OP_SIZE-1:0] {
        OP_NOP,
        OP_LOAD,
        OP_STORE,
        OP_DENSE,
        OP_CONV,
        OP_POOL,
        OP_ACT,
        OP_ADD,
        OP_MUL,
        OP_HALT,
        OP_NUM
    } op_e;

    localparam int NUM_OPS = int'(OP_NUM);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0]       code;
        logic [DEF_REPEAT_W-1:0] rpt;
    } entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with wrap-around pointers; one extra pointer bit
// distinguishes full from empty.
module instr_fifo
    import instr_pkg::*;
#(
    parameter type T     = entry_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW:0]    r_wp;
    logic [AW:0]    r_rp;
    logic           w_wr;
    logic           w_rd;

    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs opcode/parameter fields into code words, queues them and issues each
// one repeat+1 times. Optional opcode check: define INSTR_ENC_OPCHECK_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int OP_SIZE      = DEF_OP_SIZE,
    parameter int PARAM_A_SIZE = DEF_PARAM_A_SIZE,
    parameter int PARAM_B_SIZE = DEF_PARAM_B_SIZE,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_W     = DEF_REPEAT_W,
    parameter int CNT_W        = 16,
    parameter int NUM_OPS_P    = NUM_OPS
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [OP_SIZE-1:0]                     in_op,
    input  logic [PARAM_A_SIZE-1:0]                in_act_type,
    input  logic [PARAM_B_SIZE-1:0]                in_dense_type,
    input  logic                                   in_cost_mode,
    input  logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]   in_cost_type,
    input  logic [REPEAT_W-1:0]                    in_repeat,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] out_code,
    output logic                                   out_last,
    output logic                                   busy,
    output logic [CNT_W-1:0]                       issued_count,
    output logic                                   err_illegal_op
);

    localparam int CW = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;

    typedef struct packed {
        logic [CW-1:0]       code;
        logic [REPEAT_W-1:0] rpt;
    } ent_t;

    state_e              r_state;
    logic [CW-1:0]       r_code;
    logic [REPEAT_W-1:0] r_rep;
    logic                r_valid;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;

    ent_t                w_wdata;
    ent_t                w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_legal;
    logic                w_push;
    logic                w_pop;
    logic                w_fire;

    always_comb begin
        w_wdata = '0;
        if (in_cost_mode)
            w_wdata.code = {in_op, in_cost_type};
        else
            w_wdata.code = {in_op, in_act_type, in_dense_type};
        w_wdata.rpt = in_repeat;
    end

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_fire   = r_valid && out_ready;

    // Pop to start a new instruction, or to chain the next one with no bubble.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || (w_fire && (r_rep == '0)));

`ifdef INSTR_ENC_OPCHECK_EN
    logic r_err;

    assign w_legal = (int'(in_op) < NUM_OPS_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept && !w_legal)
            r_err <= 1'b1;
    end

    assign err_illegal_op = r_err;
`else
    assign w_legal        = 1'b1;
    assign err_illegal_op = 1'b0;
`endif

    instr_fifo #(
        .T     (ent_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_rep   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_fire) r_cnt <= r_cnt + 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_code  <= w_head.code;
                        r_rep   <= w_head.rpt;
                        r_last  <= (w_head.rpt == '0);
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_fire) begin
                        if (r_rep != '0) begin
                            r_rep  <= r_rep - 1'b1;
                            r_last <= (r_rep == REPEAT_W'(1));
                        end else if (!w_empty) begin
                            r_code  <= w_head.code;
                            r_rep   <= w_head.rpt;
                            r_last  <= (w_head.rpt == '0);
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid    = r_valid;
    assign out_code     = r_code;
    assign out_last     = r_last;
    assign issued_count = r_cnt;
    assign busy         = (r_state == ISSUE) || !w_empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven vectors feeding a
// scoreboard queue, plus hand-written stall/full/reset/opcode sequences.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_act_type;
    logic [3:0]  in_dense_type;
    logic        in_cost_mode;
    logic [7:0]  in_cost_type;
    logic [3:0]  in_repeat;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_code;
    logic        out_last;
    logic        busy;
    logic [15:0] issued_count;
    logic        err_illegal_op;

    instr_encoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_act_type    (in_act_type),
        .in_dense_type  (in_dense_type),
        .in_cost_mode   (in_cost_mode),
        .in_cost_type   (in_cost_type),
        .in_repeat      (in_repeat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_code       (out_code),
        .out_last       (out_last),
        .busy           (busy),
        .issued_count   (issued_count),
        .err_illegal_op (err_illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  act;
        logic [3:0]  dense;
        logic        cm;
        logic [7:0]  cost;
        logic [3:0]  rep;
        logic [11:0] code;
    } vec_t;

    typedef struct {
        logic [11:0] code;
        logic        last;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   checks;
    int   errors;
    int   hs;
    int   acc;
    int   exp_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            hs++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none",
                         out_code);
            end else begin
                e = sbq.pop_front();
                chk("out_code", 32'(out_code), 32'(e.code));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic send(input vec_t v);
        int  t;
        bit  legal;
        legal = 1'b1;
`ifdef INSTR_ENC_OPCHECK_EN
        if (v.op >= 4'd10) legal = 1'b0;
`endif
        @(posedge clk);
        #1;
        in_op         = v.op;
        in_act_type   = v.act;
        in_dense_type = v.dense;
        in_cost_mode  = v.cm;
        in_cost_type  = v.cost;
        in_repeat     = v.rep;
        in_valid      = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (legal) begin
                for (int k = 0; k <= int'(v.rep); k++)
                    sbq.push_back('{code: v.code, last: (k == int'(v.rep))});
            end
            acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sbq.size() != 0 || busy) && t < 500);
        if (t >= 500) chk("idle_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        int   t;
        vec_t v;

        checks = 0; errors = 0; hs = 0; acc = 0; exp_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_act_type = '0; in_dense_type = '0;
        in_cost_mode = 1'b0; in_cost_type = '0; in_repeat = '0;

        vt[0] = '{4'h3, 4'h2, 4'h5, 1'b0, 8'h00, 4'd0,  12'h325};
        vt[1] = '{4'h6, 4'hF, 4'hF, 1'b1, 8'hA7, 4'd2,  12'h6A7};
        vt[2] = '{4'h9, 4'h0, 4'h0, 1'b0, 8'hFF, 4'd0,  12'h900};
        vt[3] = '{4'h9, 4'hF, 4'hF, 1'b0, 8'h00, 4'd1,  12'h9FF};
        vt[4] = '{4'h1, 4'h5, 4'h5, 1'b1, 8'h00, 4'd0,  12'h100};
        vt[5] = '{4'h0, 4'hA, 4'h3, 1'b0, 8'h5C, 4'd15, 12'h0A3};

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(issued_count), 32'd0);
        chk("rst_err", 32'(err_illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c0 = hs;
            send(vt[i]);
            wait_idle();
            exp_cnt += int'(vt[i].rep) + 1;
            chk("vec_issues", 32'(hs - c0), 32'(int'(vt[i].rep) + 1));
            chk("vec_count", 32'(issued_count), 32'(exp_cnt));
            chk("vec_busy", 32'(busy), 32'd0);
        end

        out_ready = 1'b0;
        send('{4'h2, 4'h4, 4'h8, 1'b0, 8'h00, 4'd0, 12'h248});
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_code", 32'(out_code), 32'h248);
            chk("stall_last", 32'(out_last), 32'd1);
            chk("stall_count", 32'(issued_count), 32'(exp_cnt));
        end
        c0 = hs;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        exp_cnt += 1;
        chk("stall_hs", 32'(hs - c0), 32'd1);
        chk("stall_cnt_after", 32'(issued_count), 32'(exp_cnt));

        // One word sits in the output register, so five fit before full.
        out_ready = 1'b0;
        acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    v.op = 4'(i + 1); v.act = 4'(i); v.dense = 4'hC;
                    v.cm = 1'b0; v.cost = '0; v.rep = '0;
                    v.code = {4'(i + 1), 4'(i), 4'hC};
                    send(v);
                end
            end
            begin
                t = 0;
                while (acc < 5 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(negedge clk);
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("full_accepted", 32'(acc), 32'd5);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    chk("no_bubble", 32'(out_valid), 32'd1);
                end
            end
        join
        wait_idle();
        exp_cnt += 6;
        chk("full_count", 32'(issued_count), 32'(exp_cnt));

        out_ready = 1'b1;
        c0 = hs;
        send('{4'h7, 4'h1, 4'h1, 1'b0, 8'h00, 4'd7, 12'h711});
        t = 0;
        while (hs - c0 < 3 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("pre_rst_issues", 32'(hs - c0), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(issued_count), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        sbq.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        c0 = hs;
`ifdef INSTR_ENC_OPCHECK_EN
        send('{4'hC, 4'h1, 4'h2, 1'b0, 8'h00, 4'd0, 12'hC12});
        repeat (3) @(negedge clk);
        chk("illegal_err", 32'(err_illegal_op), 32'd1);
        chk("illegal_no_out", 32'(hs - c0), 32'd0);
        chk("illegal_busy", 32'(busy), 32'd0);
        send('{4'h1, 4'h2, 4'h3, 1'b0, 8'h00, 4'd0, 12'h123});
        wait_idle();
        exp_cnt += 1;
        chk("legal_after_hs", 32'(hs - c0), 32'd1);
        chk("err_sticky", 32'(err_illegal_op), 32'd1);
`else
        send('{4'hC, 4'h1, 4'h2, 1'b0, 8'h00, 4'd0, 12'hC12});
        wait_idle();
        exp_cnt += 1;
        chk("op12_issued", 32'(hs - c0), 32'd1);
        chk("err_tied", 32'(err_illegal_op), 32'd0);
`endif
        chk("final_count", 32'(issued_count), 32'(exp_cnt));
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
